// File: rtl/data_sram_bridge_if.sv
// Split-transaction sram-like data bus between the bridge (master) and the
// memory system (slave): address handshake via data_req/data_addr_ok, data
// handshake via data_data_ok/data_rdata.
interface data_sram_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sram_bridge.sv
// Bridge from the CPU's single-cycle data-SRAM port to the split-transaction
// sram-like bus. One access is in flight at a time; the pipeline is stalled
// from the cycle the access is first seen until the DONE cycle, where the
// registered load data is presented to the MEM stage.
module data_sram_bridge (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_sram_en,
  input  logic [3:0]                 data_sram_wen,
  input  logic [31:0]                data_sram_addr,
  input  logic [31:0]                data_sram_wdata,
  output logic [31:0]                data_sram_rdata,
  output logic                       stallreq_mem,
  data_sram_bridge_if.master         bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t      state_q;
  logic        req_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        wr_d;
  logic [1:0]  size_d;

  // Decode the transfer direction and size from the byte enables; reads and
  // irregular enable patterns fall back to a full word.
  always_comb begin
    wr_d   = |data_sram_wen;
    size_d = 2'd2;
    case (data_sram_wen)
      4'b0011, 4'b1100:                   size_d = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_d = 2'd0;
      default:                            size_d = 2'd2;
    endcase
  end

  // Transaction FSM: latch the request, hold it on the bus until accepted,
  // wait for completion (capturing read data), then release the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_sram_en) begin
            addr_q  <= data_sram_addr;
            wdata_q <= data_sram_wdata;
            wr_q    <= wr_d;
            size_q  <= size_d;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus.data_addr_ok) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.data_data_ok) begin
            if (!wr_q) begin
              rdata_q <= bus.data_rdata;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall covers the cycle the access first appears (before any state has
  // changed) and every cycle until the bus has completed it.
  always_comb begin
    stallreq_mem = (state_q == REQ) || (state_q == WAIT) ||
                   ((state_q == IDLE) && data_sram_en);
  end

  assign bus.data_req     = req_q;
  assign bus.data_wr      = wr_q;
  assign bus.data_size    = size_q;
  assign bus.data_addr    = addr_q;
  assign bus.data_wdata   = wdata_q;
  assign data_sram_rdata  = rdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Testbench for data_sram_bridge: a reactive bus model with configurable
// address/data wait states, directed scenarios and a randomized sweep, all
// checked against a transaction-level model of expected stalls and data.
module tb_data_sram_bridge;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;

  data_sram_bridge_if bus ();

  data_sram_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .stallreq_mem    (stall),
    .bus             (bus.master)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] expRdata;

  int          obsStall;
  int          obsReq;
  logic        obsWr;
  logic [1:0]  obsSize;
  logic [31:0] obsAddr;
  logic [31:0] obsWdata;
  bit          obsStable;
  bit          obsTimeout;
  logic [31:0] obsRdataDone;
  logic [31:0] obsRdataStart;
  logic        obsReqAtDone;

  function automatic logic [1:0] refSize(input logic [3:0] w);
    int n;
    n = $countones(w);
    if (n == 1) return 2'd0;
    if (w == 4'b0011 || w == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  // Presents one access and plays the bus: addr_ok after addrWait extra
  // request cycles, data_ok dataWait cycles after the earliest legal cycle.
  // Returns at the negedge of the first non-stalled cycle (DONE).
  task automatic run_access(input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] busData,
                            input int addrWait, input int dataWait);
    int reqCnt;
    int dataCnt;
    int phase;
    @(posedge clk); #1;
    en = 1'b1; wen = w; addr = a; wdata = d;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    reqCnt = 0; dataCnt = 0; phase = 0;
    obsStall = 0; obsReq = 0; obsStable = 1'b1; obsTimeout = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) obsRdataStart = rdata;
      if (bus.data_req === 1'b1) begin
        if (obsReq == 0) begin
          obsWr = bus.data_wr; obsSize = bus.data_size;
          obsAddr = bus.data_addr; obsWdata = bus.data_wdata;
        end else if (bus.data_wr !== obsWr || bus.data_size !== obsSize ||
                     bus.data_addr !== obsAddr || bus.data_wdata !== obsWdata) begin
          obsStable = 1'b0;
        end
        obsReq++;
      end
      if (stall === 1'b1) begin
        obsStall++;
      end else begin
        obsTimeout = 1'b0;
        obsRdataDone = rdata;
        obsReqAtDone = bus.data_req;
        break;
      end
      @(posedge clk); #1;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
      if (phase == 1) begin
        dataCnt++;
        if (dataCnt > dataWait) begin
          bus.data_data_ok = 1'b1; bus.data_rdata = busData; phase = 2;
        end
      end else if (phase == 0 && bus.data_req === 1'b1) begin
        reqCnt++;
        if (reqCnt > addrWait) begin
          bus.data_addr_ok = 1'b1; phase = 1;
        end
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    en = 1'b0; wen = 4'd0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; wen = 4'd0; addr = 32'd0; wdata = 32'd0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++; if (bus.data_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_req: got %b expected 0", bus.data_req); end
    compared++; if (bus.data_wr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wr: got %b expected 0", bus.data_wr); end
    compared++; if (bus.data_size !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_size: got %0d expected 0", bus.data_size); end
    compared++; if (bus.data_addr !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_addr: got %h expected 0", bus.data_addr); end
    compared++; if (bus.data_wdata !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_wdata: got %h expected 0", bus.data_wdata); end
    compared++; if (rdata !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    expRdata = 32'd0;
  endtask

  task automatic test_read_zero_wait();
    run_access(4'b0000, 32'h0000_1000, $urandom, 32'hDEAD_BEEF, 0, 0);
    expRdata = 32'hDEAD_BEEF;
    compared++; if (obsTimeout) begin mismatched++; $display("[TB] FAIL read0_timeout: got stalled expected completion"); end
    compared++; if (obsStall !== 3) begin mismatched++; $display("[TB] FAIL read0_stall: got %0d expected 3", obsStall); end
    compared++; if (obsReq !== 1) begin mismatched++; $display("[TB] FAIL read0_reqcycles: got %0d expected 1", obsReq); end
    compared++; if (obsWr !== 1'b0) begin mismatched++; $display("[TB] FAIL read0_wr: got %b expected 0", obsWr); end
    compared++; if (obsSize !== 2'd2) begin mismatched++; $display("[TB] FAIL read0_size: got %0d expected 2", obsSize); end
    compared++; if (obsAddr !== 32'h0000_1000) begin mismatched++; $display("[TB] FAIL read0_addr: got %h expected 00001000", obsAddr); end
    compared++; if (obsRdataDone !== expRdata) begin mismatched++; $display("[TB] FAIL read0_rdata_done: got %h expected %h", obsRdataDone, expRdata); end
    compared++; if (obsReqAtDone !== 1'b0) begin mismatched++; $display("[TB] FAIL read0_req_done: got %b expected 0", obsReqAtDone); end
    for (int i = 0; i < 2; i++) begin
      idle_cycle();
      compared++; if (rdata !== expRdata) begin mismatched++; $display("[TB] FAIL read0_rdata_hold%0d: got %h expected %h", i, rdata, expRdata); end
    end
  endtask

  task automatic test_store_backpressure();
    run_access(4'b0100, 32'h0000_2002, 32'h00AB_0000, $urandom, 3, 1);
    compared++; if (obsTimeout) begin mismatched++; $display("[TB] FAIL sb_timeout: got stalled expected completion"); end
    compared++; if (obsStall !== 7) begin mismatched++; $display("[TB] FAIL sb_stall: got %0d expected 7", obsStall); end
    compared++; if (obsReq !== 4) begin mismatched++; $display("[TB] FAIL sb_reqcycles: got %0d expected 4", obsReq); end
    compared++; if (!obsStable) begin mismatched++; $display("[TB] FAIL sb_stable: got changing request expected constant"); end
    compared++; if (obsWr !== 1'b1) begin mismatched++; $display("[TB] FAIL sb_wr: got %b expected 1", obsWr); end
    compared++; if (obsSize !== 2'd0) begin mismatched++; $display("[TB] FAIL sb_size: got %0d expected 0", obsSize); end
    compared++; if (obsAddr !== 32'h0000_2002) begin mismatched++; $display("[TB] FAIL sb_addr: got %h expected 00002002", obsAddr); end
    compared++; if (obsWdata !== 32'h00AB_0000) begin mismatched++; $display("[TB] FAIL sb_wdata: got %h expected 00ab0000", obsWdata); end
    compared++; if (obsRdataDone !== expRdata) begin mismatched++; $display("[TB] FAIL sb_rdata: got %h expected %h", obsRdataDone, expRdata); end
    idle_cycle();
  endtask

  task automatic test_size_encoding();
    logic [3:0]  w;
    logic [31:0] bd;
    for (int i = 0; i < 16; i++) begin
      w = 4'(i);
      bd = $urandom;
      run_access(w, $urandom, $urandom, bd, 0, 0);
      if (w == 4'd0) expRdata = bd;
      compared++; if (obsTimeout) begin mismatched++; $display("[TB] FAIL size_timeout wen=%b: got stalled expected completion", w); end
      compared++; if (obsWr !== (w != 4'd0)) begin mismatched++; $display("[TB] FAIL size_wr wen=%b: got %b expected %b", w, obsWr, (w != 4'd0)); end
      compared++; if (obsSize !== refSize(w)) begin mismatched++; $display("[TB] FAIL size_size wen=%b: got %0d expected %0d", w, obsSize, refSize(w)); end
      compared++; if (obsRdataDone !== expRdata) begin mismatched++; $display("[TB] FAIL size_rdata wen=%b: got %h expected %h", w, obsRdataDone, expRdata); end
      idle_cycle();
    end
  endtask

  task automatic test_back_to_back();
    run_access(4'b0000, 32'h0000_3000, 32'd0, 32'h1111_1111, 0, 0);
    compared++; if (obsRdataDone !== 32'h1111_1111) begin mismatched++; $display("[TB] FAIL b2b_rdata1: got %h expected 11111111", obsRdataDone); end
    compared++; if (obsReqAtDone !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_req_done1: got %b expected 0", obsReqAtDone); end
    run_access(4'b0000, 32'h0000_3004, 32'd0, 32'h2222_2222, 0, 0);
    compared++; if (obsStall !== 3) begin mismatched++; $display("[TB] FAIL b2b_stall2: got %0d expected 3", obsStall); end
    compared++; if (obsReq !== 1) begin mismatched++; $display("[TB] FAIL b2b_reqcycles2: got %0d expected 1", obsReq); end
    compared++; if (obsAddr !== 32'h0000_3004) begin mismatched++; $display("[TB] FAIL b2b_addr2: got %h expected 00003004", obsAddr); end
    compared++; if (obsRdataStart !== 32'h1111_1111) begin mismatched++; $display("[TB] FAIL b2b_rdata_start2: got %h expected 11111111", obsRdataStart); end
    compared++; if (obsRdataDone !== 32'h2222_2222) begin mismatched++; $display("[TB] FAIL b2b_rdata2: got %h expected 22222222", obsRdataDone); end
    expRdata = 32'h2222_2222;
    idle_cycle();
  endtask

  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    en = 1'b1; wen = 4'd0; addr = 32'h0000_4000;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0; rst = 1'b1; en = 1'b0;
    @(negedge clk);
    compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL rstw_stall_wait: got %b expected 1", stall); end
    @(posedge clk); #1;
    rst = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL rstw_stall: got %b expected 0", stall); end
    compared++; if (bus.data_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rstw_req: got %b expected 0", bus.data_req); end
    compared++; if (rdata !== 32'd0) begin mismatched++; $display("[TB] FAIL rstw_rdata_clear: got %h expected 0", rdata); end
    @(posedge clk); #1;
    bus.data_data_ok = 1'b0;
    @(negedge clk);
    expRdata = 32'd0;
    compared++; if (rdata !== expRdata) begin mismatched++; $display("[TB] FAIL rstw_rdata_nocapture: got %h expected %h", rdata, expRdata); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL rstw_stall_after: got %b expected 0", stall); end
    run_access(4'b0000, 32'h0000_4004, 32'd0, 32'hCAFE_F00D, 0, 0);
    expRdata = 32'hCAFE_F00D;
    compared++; if (obsStall !== 3) begin mismatched++; $display("[TB] FAIL rstw_next_stall: got %0d expected 3", obsStall); end
    compared++; if (obsRdataDone !== expRdata) begin mismatched++; $display("[TB] FAIL rstw_next_rdata: got %h expected %h", obsRdataDone, expRdata); end
    idle_cycle();
  endtask

  task automatic test_spurious_data_ok();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      en = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = $urandom;
      @(negedge clk);
      compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL spur_stall%0d: got %b expected 0", i, stall); end
      compared++; if (bus.data_req !== 1'b0) begin mismatched++; $display("[TB] FAIL spur_req%0d: got %b expected 0", i, bus.data_req); end
    end
    idle_cycle();
    compared++; if (rdata !== expRdata) begin mismatched++; $display("[TB] FAIL spur_rdata: got %h expected %h", rdata, expRdata); end
    run_access(4'b0000, 32'h0000_5000, 32'd0, 32'h5A5A_A5A5, 1, 0);
    expRdata = 32'h5A5A_A5A5;
    compared++; if (obsStall !== 4) begin mismatched++; $display("[TB] FAIL spur_next_stall: got %0d expected 4", obsStall); end
    compared++; if (obsReq !== 2) begin mismatched++; $display("[TB] FAIL spur_next_req: got %0d expected 2", obsReq); end
    compared++; if (obsRdataDone !== expRdata) begin mismatched++; $display("[TB] FAIL spur_next_rdata: got %h expected %h", obsRdataDone, expRdata); end
    idle_cycle();
  endtask

  task automatic test_random();
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] bd;
    int          aw;
    int          dw;
    for (int n = 0; n < 24; n++) begin
      w  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      a  = $urandom; d = $urandom; bd = $urandom;
      aw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
      run_access(w, a, d, bd, aw, dw);
      if (w == 4'd0) expRdata = bd;
      compared++; if (obsTimeout) begin mismatched++; $display("[TB] FAIL rnd%0d_timeout: got stalled expected completion", n); end
      compared++; if (obsStall !== 3 + aw + dw) begin mismatched++; $display("[TB] FAIL rnd%0d_stall: got %0d expected %0d", n, obsStall, 3 + aw + dw); end
      compared++; if (obsReq !== aw + 1) begin mismatched++; $display("[TB] FAIL rnd%0d_req: got %0d expected %0d", n, obsReq, aw + 1); end
      compared++; if (!obsStable) begin mismatched++; $display("[TB] FAIL rnd%0d_stable: got changing request expected constant", n); end
      compared++; if (obsWr !== (w != 4'd0)) begin mismatched++; $display("[TB] FAIL rnd%0d_wr: got %b expected %b", n, obsWr, (w != 4'd0)); end
      compared++; if (obsSize !== refSize(w)) begin mismatched++; $display("[TB] FAIL rnd%0d_size: got %0d expected %0d", n, obsSize, refSize(w)); end
      compared++; if (obsAddr !== a) begin mismatched++; $display("[TB] FAIL rnd%0d_addr: got %h expected %h", n, obsAddr, a); end
      compared++; if (obsWdata !== d) begin mismatched++; $display("[TB] FAIL rnd%0d_wdata: got %h expected %h", n, obsWdata, d); end
      compared++; if (obsRdataDone !== expRdata) begin mismatched++; $display("[TB] FAIL rnd%0d_rdata: got %h expected %h", n, obsRdataDone, expRdata); end
      if ($urandom_range(0, 1) == 1) begin
        idle_cycle();
        compared++; if (rdata !== expRdata) begin mismatched++; $display("[TB] FAIL rnd%0d_rdata_hold: got %h expected %h", n, rdata, expRdata); end
      end
    end
    idle_cycle();
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_read_zero_wait();
    test_store_backpressure();
    test_size_encoding();
    test_back_to_back();
    test_reset_in_wait();
    test_spurious_data_ok();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
